// File: rtl/fft8_stage3_bfly_pkg.sv
// Shared constants and encodings for the 8-point FFT pipeline.
package fft8_stage3_bfly_pkg;

  localparam int unsigned FFT_DATA_W = 16;
  localparam int unsigned FFT_OUT_W  = FFT_DATA_W + 1;
  localparam int unsigned FFT_SEL_W  = 2;
  localparam int unsigned FFT_IDX_W  = 3;

  // Stage mux select issued by the mux controller.
  typedef enum logic [FFT_SEL_W-1:0] {
    SEL_STORE   = 2'd0,
    SEL_BFLY    = 2'd1,
    SEL_IDLE    = 2'd2,
    SEL_ILLEGAL = 2'd3
  } sel_e;

endpackage

// File: rtl/fft8_stage3_bfly_if.sv
// Sample stream in, butterfly results out, for the stage-3 butterfly.
interface fft8_stage3_bfly_if
  import fft8_stage3_bfly_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W
);

  localparam int unsigned OUT_W = DATA_W + 1;

  logic [FFT_SEL_W-1:0]     sel;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_re;
  logic signed [OUT_W-1:0]  out_im;
  logic [FFT_IDX_W-1:0]     out_idx;
  logic                     err;

  modport master (
    output sel, in_valid, in_re, in_im,
    input  out_valid, out_re, out_im, out_idx, err
  );

  modport slave (
    input  sel, in_valid, in_re, in_im,
    output out_valid, out_re, out_im, out_idx, err
  );

endinterface

// File: rtl/fft8_stage3_bfly_cbfly_addsub.sv
// Combinational signed complex add/sub with one bit of growth.
module cbfly_addsub #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = IN_W + 1
) (
  input  logic signed [IN_W-1:0]  i_a_re,
  input  logic signed [IN_W-1:0]  i_a_im,
  input  logic signed [IN_W-1:0]  i_b_re,
  input  logic signed [IN_W-1:0]  i_b_im,
  output logic signed [OUT_W-1:0] o_sum_re_c,
  output logic signed [OUT_W-1:0] o_sum_im_c,
  output logic signed [OUT_W-1:0] o_diff_re_c,
  output logic signed [OUT_W-1:0] o_diff_im_c
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  logic signed [OUT_W-1:0] w_a_re;
  logic signed [OUT_W-1:0] w_a_im;
  logic signed [OUT_W-1:0] w_b_re;
  logic signed [OUT_W-1:0] w_b_im;

  // Sign-extend operands so the result never wraps.
  assign w_a_re = {{EXT_W{i_a_re[IN_W-1]}}, i_a_re};
  assign w_a_im = {{EXT_W{i_a_im[IN_W-1]}}, i_a_im};
  assign w_b_re = {{EXT_W{i_b_re[IN_W-1]}}, i_b_re};
  assign w_b_im = {{EXT_W{i_b_im[IN_W-1]}}, i_b_im};

  assign o_sum_re_c  = w_a_re + w_b_re;
  assign o_sum_im_c  = w_a_im + w_b_im;
  assign o_diff_re_c = w_a_re - w_b_re;
  assign o_diff_im_c = w_a_im - w_b_im;

endmodule

// File: rtl/fft8_stage3_bfly.sv
// Final SDF radix-2 butterfly: emits sum then difference for each sample pair.
module fft8_stage3_bfly
  import fft8_stage3_bfly_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  fft8_stage3_bfly_if.slave   bus
);

  localparam int unsigned OUT_W = DATA_W + 1;

  sel_e                     w_sel;
  logic signed [OUT_W-1:0]  w_sum_re;
  logic signed [OUT_W-1:0]  w_sum_im;
  logic signed [OUT_W-1:0]  w_diff_re;
  logic signed [OUT_W-1:0]  w_diff_im;

  logic signed [DATA_W-1:0] r_hold_re;
  logic signed [DATA_W-1:0] r_hold_im;
  logic                     r_hold_full;
  logic signed [OUT_W-1:0]  r_diff_re;
  logic signed [OUT_W-1:0]  r_diff_im;
  logic                     r_diff_pend;
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_re;
  logic signed [OUT_W-1:0]  r_out_im;
  logic [FFT_IDX_W-1:0]     r_out_idx;
  logic                     r_err;

  logic signed [DATA_W-1:0] w_nxt_hold_re;
  logic signed [DATA_W-1:0] w_nxt_hold_im;
  logic                     w_nxt_hold_full;
  logic signed [OUT_W-1:0]  w_nxt_diff_re;
  logic signed [OUT_W-1:0]  w_nxt_diff_im;
  logic                     w_nxt_diff_pend;
  logic                     w_nxt_out_valid;
  logic signed [OUT_W-1:0]  w_nxt_out_re;
  logic signed [OUT_W-1:0]  w_nxt_out_im;
  logic                     w_nxt_err;
  logic                     w_flush;

  assign w_sel = sel_e'(bus.sel);

  cbfly_addsub #(
    .IN_W  (DATA_W),
    .OUT_W (OUT_W)
  ) u_addsub (
    .i_a_re      (r_hold_re),
    .i_a_im      (r_hold_im),
    .i_b_re      (bus.in_re),
    .i_b_im      (bus.in_im),
    .o_sum_re_c  (w_sum_re),
    .o_sum_im_c  (w_sum_im),
    .o_diff_re_c (w_diff_re),
    .o_diff_im_c (w_diff_im)
  );

  // Next-state decode: store, butterfly, or flush a pending difference.
  always_comb begin
    w_nxt_hold_re   = r_hold_re;
    w_nxt_hold_im   = r_hold_im;
    w_nxt_hold_full = r_hold_full;
    w_nxt_diff_re   = r_diff_re;
    w_nxt_diff_im   = r_diff_im;
    w_nxt_diff_pend = r_diff_pend;
    w_nxt_out_valid = 1'b0;
    w_nxt_out_re    = r_out_re;
    w_nxt_out_im    = r_out_im;
    w_nxt_err       = r_err;
    w_flush         = 1'b0;

    case (w_sel)
      SEL_STORE: begin
        if (bus.in_valid) begin
          if (r_hold_full) w_nxt_err = 1'b1;
          w_nxt_hold_re   = bus.in_re;
          w_nxt_hold_im   = bus.in_im;
          w_nxt_hold_full = 1'b1;
        end else begin
          w_nxt_err = 1'b1;
        end
        w_flush = 1'b1;
      end
      SEL_BFLY: begin
        if (bus.in_valid && r_hold_full) begin
          w_nxt_out_valid = 1'b1;
          w_nxt_out_re    = w_sum_re;
          w_nxt_out_im    = w_sum_im;
          w_nxt_diff_re   = w_diff_re;
          w_nxt_diff_im   = w_diff_im;
          w_nxt_diff_pend = 1'b1;
          w_nxt_hold_full = 1'b0;
        end else if (bus.in_valid) begin
          // Butterfly with nothing held: state untouched, no flush.
          w_nxt_err = 1'b1;
        end else begin
          w_nxt_err = 1'b1;
          w_flush   = 1'b1;
        end
      end
      default: begin
        if (w_sel == SEL_ILLEGAL) w_nxt_err = 1'b1;
        w_flush = 1'b1;
      end
    endcase

    if (w_flush && r_diff_pend) begin
      w_nxt_out_valid = 1'b1;
      w_nxt_out_re    = r_diff_re;
      w_nxt_out_im    = r_diff_im;
      w_nxt_diff_pend = 1'b0;
    end
  end

  // State, flag and output registers; index advances after each valid output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_re   <= '0;
      r_hold_im   <= '0;
      r_hold_full <= 1'b0;
      r_diff_re   <= '0;
      r_diff_im   <= '0;
      r_diff_pend <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_idx   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_hold_re   <= w_nxt_hold_re;
      r_hold_im   <= w_nxt_hold_im;
      r_hold_full <= w_nxt_hold_full;
      r_diff_re   <= w_nxt_diff_re;
      r_diff_im   <= w_nxt_diff_im;
      r_diff_pend <= w_nxt_diff_pend;
      r_out_valid <= w_nxt_out_valid;
      r_out_re    <= w_nxt_out_re;
      r_out_im    <= w_nxt_out_im;
      r_out_idx   <= r_out_idx + FFT_IDX_W'(r_out_valid);
      r_err       <= w_nxt_err;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_re    = r_out_re;
  assign bus.out_im    = r_out_im;
  assign bus.out_idx   = r_out_idx;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_fft8_stage3_bfly.sv
// Randomized self-checking bench for the stage-3 butterfly.
module tb_fft8_stage3_bfly;
  import fft8_stage3_bfly_pkg::*;

  localparam int unsigned DW = FFT_DATA_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft8_stage3_bfly_if #(.DATA_W(DW)) bus ();

  fft8_stage3_bfly #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int re;
    int im;
    int idx;
    int cyc;
  } obs_t;
  obs_t got_q[$];

  // Reference model state (plain integers).
  bit m_valid, m_err, h_full, d_pend;
  int m_re, m_im, m_idx, h_re, h_im, d_re, d_im;

  int nom_re[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int nom_im[8] = '{0, 0, 0, 0, 1, 1, -1, 2};
  int exp_re[8] = '{3, -1, 7, -1, 11, -1, 15, -1};
  int exp_im[8] = '{0, 0, 0, 0, 2, 0, 1, -3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Behavioural model: what the butterfly stage must emit after each edge.
  always @(posedge clk or negedge rst_n) begin
    int s, xr, xi;
    bit emit;
    if (!rst_n) begin
      m_valid = 0; m_err = 0; h_full = 0; d_pend = 0;
      m_re = 0; m_im = 0; m_idx = 0; h_re = 0; h_im = 0; d_re = 0; d_im = 0;
    end else begin
      s  = int'(bus.sel);
      xr = int'(bus.in_re);
      xi = int'(bus.in_im);
      if (m_valid) m_idx = (m_idx + 1) % 8;
      emit = 0;
      if (s == 1 && bus.in_valid && h_full) begin
        m_re = h_re + xr; m_im = h_im + xi;
        d_re = h_re - xr; d_im = h_im - xi;
        d_pend = 1; h_full = 0; emit = 1;
      end else if (s == 1 && bus.in_valid) begin
        m_err = 1;
      end else begin
        if (s == 0 && bus.in_valid) begin
          if (h_full) m_err = 1;
          h_re = xr; h_im = xi; h_full = 1;
        end else if (s != 2) begin
          m_err = 1;
        end
        if (d_pend) begin
          m_re = d_re; m_im = d_im; d_pend = 0; emit = 1;
        end
      end
      m_valid = emit;
    end
  end

  // Cycle-by-cycle comparison against the model, plus output capture.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(bus.out_valid), int'(m_valid));
      chk("err", int'(bus.err), int'(m_err));
      chk("out_idx", int'(bus.out_idx), m_idx);
      chk("out_re", int'(bus.out_re), m_re);
      chk("out_im", int'(bus.out_im), m_im);
      if (bus.out_valid)
        got_q.push_back('{int'(bus.out_re), int'(bus.out_im), int'(bus.out_idx), cyc});
    end
  end

  task automatic drv(input int s, input bit v, input int re, input int im);
    bus.sel      = FFT_SEL_W'(s);
    bus.in_valid = v;
    bus.in_re    = DW'(re);
    bus.in_im    = DW'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int xr[8], input int xi[8]);
    for (int i = 0; i < 8; i++) drv(i % 2, 1'b1, xr[i], xi[i]);
    drv(2, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int rr[8], ri[8];
    int t0;
    bus.sel = FFT_SEL_W'(2); bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_err", int'(bus.err), 0);
    chk("reset_idx", int'(bus.out_idx), 0);
    chk("reset_re", int'(bus.out_re), 0);
    chk("reset_im", int'(bus.out_im), 0);
    rst_n = 1'b1;
    drv(2, 1'b0, 0, 0);

    // Nominal frame followed back-to-back by a random frame.
    for (int i = 0; i < 8; i++) begin rr[i] = rnd16(); ri[i] = rnd16(); end
    got_q.delete();
    t0 = cyc;
    frame(nom_re, nom_im);
    frame(rr, ri);
    repeat (3) drv(2, 1'b0, 0, 0);
    chk("b2b_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("first_latency", got_q[0].cyc - t0, 2);
      for (int i = 0; i < 8; i++) begin
        chk("nom_re", got_q[i].re, exp_re[i]);
        chk("nom_im", got_q[i].im, exp_im[i]);
        chk("nom_idx", got_q[i].idx, i);
        chk("nom_consec", got_q[i].cyc - got_q[0].cyc, i);
        chk("f2_idx", got_q[8 + i].idx, i);
        chk("f2_consec", got_q[8 + i].cyc - got_q[8].cyc, i);
      end
      for (int p = 0; p < 4; p++) begin
        chk("f2_sum_re", got_q[8 + 2*p].re, rr[2*p] + rr[2*p+1]);
        chk("f2_sum_im", got_q[8 + 2*p].im, ri[2*p] + ri[2*p+1]);
        chk("f2_diff_re", got_q[9 + 2*p].re, rr[2*p] - rr[2*p+1]);
        chk("f2_diff_im", got_q[9 + 2*p].im, ri[2*p] - ri[2*p+1]);
      end
    end
    chk("b2b_err", int'(bus.err), 0);

    // Width growth at the extremes.
    got_q.delete();
    drv(0, 1'b1, 32767, -32768);
    drv(1, 1'b1, 32767, -32768);
    drv(2, 1'b0, 0, 0);
    drv(2, 1'b0, 0, 0);
    chk("wide_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("wide_sum_re", got_q[0].re, 65534);
      chk("wide_sum_im", got_q[0].im, -65536);
      chk("wide_diff_re", got_q[1].re, 0);
      chk("wide_diff_im", got_q[1].im, 0);
    end
    chk("wide_err", int'(bus.err), 0);

    // Missing input on the store slot after a butterfly still flushes diff.
    drv(0, 1'b1, 10, -4);
    drv(1, 1'b1, 3, 5);
    chk("miss_sum_re", int'(bus.out_re), 13);
    chk("miss_sum_im", int'(bus.out_im), 1);
    chk("miss_err_before", int'(bus.err), 0);
    drv(0, 1'b0, 0, 0);
    chk("miss_valid", int'(bus.out_valid), 1);
    chk("miss_diff_re", int'(bus.out_re), 7);
    chk("miss_diff_im", int'(bus.out_im), -9);
    chk("miss_err", int'(bus.err), 1);

    // Butterfly with empty hold.
    do_reset();
    drv(2, 1'b0, 0, 0);
    drv(1, 1'b1, 5, 5);
    chk("empty_valid", int'(bus.out_valid), 0);
    chk("empty_err", int'(bus.err), 1);
    repeat (4) drv(2, 1'b0, 0, 0);
    chk("empty_err_sticky", int'(bus.err), 1);

    // Illegal select.
    do_reset();
    chk("illegal_err_before", int'(bus.err), 0);
    drv(3, 1'b1, 9, 9);
    chk("illegal_valid", int'(bus.out_valid), 0);
    chk("illegal_err", int'(bus.err), 1);
    frame(nom_re, nom_im);
    chk("illegal_err_sticky", int'(bus.err), 1);

    // Reset mid-frame after the third output.
    do_reset();
    for (int i = 0; i < 4; i++) drv(i % 2, 1'b1, nom_re[i], nom_im[i]);
    chk("mid_pre_valid", int'(bus.out_valid), 1);
    chk("mid_pre_idx", int'(bus.out_idx), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", int'(bus.out_valid), 0);
    chk("mid_re", int'(bus.out_re), 0);
    chk("mid_im", int'(bus.out_im), 0);
    chk("mid_idx", int'(bus.out_idx), 0);
    chk("mid_err", int'(bus.err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    frame(nom_re, nom_im);
    drv(2, 1'b0, 0, 0);
    chk("restart_count", got_q.size(), 8);
    if (got_q.size() == 8) begin
      chk("restart_idx0", got_q[0].idx, 0);
      chk("restart_re0", got_q[0].re, 3);
      chk("restart_idx7", got_q[7].idx, 7);
      chk("restart_im7", got_q[7].im, -3);
    end

    // Random frames with occasional protocol perturbations.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 9; k++) begin
        int s;
        bit v;
        s = (k == 8) ? 2 : (k % 2);
        v = (k != 8);
        if (f >= 20 && $urandom_range(0, 99) < 10) begin
          s = int'($urandom_range(0, 3));
          v = 1'($urandom_range(0, 1));
        end
        drv(s, v, rnd16(), rnd16());
      end
      if (f == 30) do_reset();
    end
    repeat (3) drv(2, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
